// File: rtl/imem_loader_if.sv
// Stream-in / byte-write-out bundle of the instruction memory loader.
// The slave modport is the loader; the master modport is the boot/debug source and memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  Start;
  logic [ADDR_WIDTH-1:0] BaseAddress;
  logic [CNT_WIDTH-1:0]  WordCount;
  logic [31:0]           WordData;
  logic                  WordValid;
  logic                  WordReady;
  logic                  MemWriteEnable;
  logic [ADDR_WIDTH-1:0] MemWriteAddress;
  logic [7:0]            MemWriteData;
  logic                  Busy;
  logic                  Done;
  logic                  Error;

  modport master (
    output Start, BaseAddress, WordCount, WordData, WordValid,
    input  WordReady, MemWriteEnable, MemWriteAddress, MemWriteData, Busy, Done, Error
  );

  modport slave (
    input  Start, BaseAddress, WordCount, WordData, WordValid,
    output WordReady, MemWriteEnable, MemWriteAddress, MemWriteData, Busy, Done, Error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words from a valid/ready stream into byte-addressable IMEM,
// one little-endian byte write per cycle after each accepted word.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [31:0]           word;
  logic [1:0]            byte_idx;
  logic                  error_q;

  logic out_of_range;
  logic start_load;
  logic start_bad;
  logic take_word;
  logic range_fault;
  logic write_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    start_load   = 1'b0;
    start_bad    = 1'b0;
    take_word    = 1'b0;
    range_fault  = 1'b0;
    write_byte   = 1'b0;
    // Aligned addresses top out at 2^N-4, so the +3 probe never wraps.
    out_of_range = (cur_addr + ADDR_WIDTH'(3)) >= MEM_LIMIT;

    case (state)
      IDLE: begin
        if (bus.Start) begin
          start_load = 1'b1;
          if (bus.BaseAddress[1:0] != 2'b00) begin
            start_bad = 1'b1;
          end else if (bus.WordCount == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (out_of_range) begin
          range_fault = 1'b1;
          state_nx    = IDLE;
        end else if (bus.WordValid) begin
          take_word = 1'b1;
          state_nx  = WRITE;
        end
      end
      WRITE: begin
        write_byte = 1'b1;
        if (byte_idx == 2'd3) begin
          state_nx = (remaining == CNT_WIDTH'(1)) ? DONE : ACCEPT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    bus.WordReady       = (state == ACCEPT) && !out_of_range;
    bus.MemWriteEnable  = (state == WRITE);
    bus.MemWriteAddress = (state == WRITE) ? cur_addr + ADDR_WIDTH'(byte_idx) : '0;
    bus.MemWriteData    = (state == WRITE) ? word[{byte_idx, 3'b000} +: 8] : '0;
    bus.Busy            = (state != IDLE);
    bus.Done            = (state == DONE);
    bus.Error           = error_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
      error_q   <= 1'b0;
    end else begin
      if (start_load) begin
        cur_addr  <= bus.BaseAddress;
        remaining <= bus.WordCount;
        error_q   <= start_bad;
      end
      if (range_fault) begin
        error_q <= 1'b1;
      end
      if (take_word) begin
        word     <= bus.WordData;
        byte_idx <= '0;
      end
      if (write_byte) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          cur_addr <= cur_addr + ADDR_WIDTH'(4);
          if (remaining != '0) begin
            remaining <= remaining - CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule
